// File: rtl/change_dispenser.sv
// change_dispenser
//   Paying end of the coin interface. Accepts a change amount, pays it out
//   greedily in 5/2/1-unit coins from three stock tubes (falling back to
//   smaller coins when a tube is empty) and pulses one hopper solenoid per
//   coin. Anything it cannot pay is reported as a latched fault with the
//   unpaid remainder.
//
// Parameters
//   PULSE_CYCLES  cycles each eject line is held high (>= 1)
//   GAP_CYCLES    idle cycles after each eject (>= 1)
//   TUBE_DEPTH    coins per tube after reset or refill (<= 255)
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active low
//   start / amount      1-cycle pay request, amount sampled when accepted
//   refill              1-cycle pulse, reload all tubes (idle only)
//   busy                high from the accepted start cycle until the done cycle
//   done                1-cycle pulse on completion or fault
//   fault / shortfall   latched "could not pay" flag and unpaid remainder
//   eject_coin1/2/5     hopper solenoids, one-hot or all low
//   tube1/2/5_count     coins left in each tube
//   paid_total          saturating audit total of all coins ejected
//
// Build option
//   CHANGE_AUDIT_EN  when defined, paid_total accumulates the value of each
//                    coin as it is ejected; otherwise it is tied to zero.

module change_dispenser #(
    parameter int PULSE_CYCLES = 50000,
    parameter int GAP_CYCLES   = 50000,
    parameter int TUBE_DEPTH   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  amount,
    input  logic        refill,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [7:0]  shortfall,
    output logic        eject_coin1,
    output logic        eject_coin2,
    output logic        eject_coin5,
    output logic [7:0]  tube1_count,
    output logic [7:0]  tube2_count,
    output logic [7:0]  tube5_count,
    output logic [15:0] paid_total
);

    localparam int TMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       TUBE_INIT  = 8'(TUBE_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJECT  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [7:0]       remaining_q;
    logic [2:0]       sel_q;        // one-hot {coin5, coin2, coin1} being ejected
    logic             fault_q;
    logic [7:0]       shortfall_q;
    logic [7:0]       tube1_q, tube2_q, tube5_q;
    logic [2:0]       pick;
    logic [7:0]       pick_value;

    function automatic logic [7:0] coin_value(input logic [2:0] onehot);
        logic [7:0] v;
        case (onehot)
            3'b100:  v = 8'd5;
            3'b010:  v = 8'd2;
            3'b001:  v = 8'd1;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Next state and greedy coin choice
    always_comb begin
        state_d = state_q;
        pick    = 3'b000;
        case (state_q)
            IDLE: begin
                if (start) state_d = SELECT;
            end
            SELECT: begin
                if (remaining_q >= 8'd5 && tube5_q != 8'd0)
                    pick = 3'b100;
                else if (remaining_q >= 8'd2 && tube2_q != 8'd0)
                    pick = 3'b010;
                else if (remaining_q != 8'd0 && tube1_q != 8'd0)
                    pick = 3'b001;

                if (pick != 3'b000)
                    state_d = EJECT;
                else if (remaining_q == 8'd0)
                    state_d = DONE;
                else
                    state_d = FAULT;
            end
            EJECT: begin
                if (tmr_q == PULSE_LAST) state_d = GAP;
            end
            GAP: begin
                if (tmr_q == GAP_LAST) state_d = SELECT;
            end
            DONE, FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pick_value = coin_value(pick);

    // State, timer, payment bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            remaining_q <= 8'd0;
            sel_q       <= 3'b000;
            fault_q     <= 1'b0;
            shortfall_q <= 8'd0;
            tube1_q     <= TUBE_INIT;
            tube2_q     <= TUBE_INIT;
            tube5_q     <= TUBE_INIT;
        end else begin
            state_q <= state_d;

            // Timer restarts on every state change, counts while dwelling.
            if ((state_q == EJECT || state_q == GAP) && state_d == state_q)
                tmr_q <= tmr_q + 1'b1;
            else
                tmr_q <= '0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        remaining_q <= amount;
                        fault_q     <= 1'b0;
                        shortfall_q <= 8'd0;
                    end else if (refill) begin
                        tube1_q <= TUBE_INIT;
                        tube2_q <= TUBE_INIT;
                        tube5_q <= TUBE_INIT;
                    end
                end
                SELECT: begin
                    if (pick != 3'b000) begin
                        // Pick only happens on a non-empty tube, so no underflow.
                        remaining_q <= remaining_q - pick_value;
                        sel_q       <= pick;
                        if (pick[2]) tube5_q <= tube5_q - 8'd1;
                        if (pick[1]) tube2_q <= tube2_q - 8'd1;
                        if (pick[0]) tube1_q <= tube1_q - 8'd1;
                    end else if (remaining_q != 8'd0) begin
                        // Entering FAULT: record what could not be paid.
                        fault_q     <= 1'b1;
                        shortfall_q <= remaining_q;
                        remaining_q <= 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CHANGE_AUDIT_EN
    logic [15:0] paid_q;

    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [7:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {9'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Credited when the coin is committed, i.e. on entry to EJECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            paid_q <= 16'd0;
        else if (state_q == SELECT && pick != 3'b000)
            paid_q <= sat_add16(paid_q, pick_value);
    end

    assign paid_total = paid_q;
`else
    assign paid_total = 16'd0;
`endif

    // Ejects decode straight from state so reset drops them asynchronously.
    assign eject_coin5 = (state_q == EJECT) && sel_q[2];
    assign eject_coin2 = (state_q == EJECT) && sel_q[1];
    assign eject_coin1 = (state_q == EJECT) && sel_q[0];

    // busy covers the accepting start cycle itself, and drops in the done cycle.
    assign busy = (state_q == IDLE) ? (start && rst)
                                    : (state_q != DONE && state_q != FAULT);
    assign done = (state_q == DONE) || (state_q == FAULT);

    assign fault       = fault_q;
    assign shortfall   = shortfall_q;
    assign tube1_count = tube1_q;
    assign tube2_count = tube2_q;
    assign tube5_count = tube5_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser (PULSE=2, GAP=2, TUBE_DEPTH=3).
// Stimulus pushes expected coins and expected completion records; a monitor
// sampling on the falling clock edge pops and compares them.
module tb_change_dispenser;

    localparam int PULSE = 2;
    localparam int GAP   = 2;
    localparam int DEPTH = 3;
`ifdef CHANGE_AUDIT_EN
    localparam bit AUDIT = 1'b1;
`else
    localparam bit AUDIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  amount;
    logic        refill;
    logic        busy, done, fault;
    logic [7:0]  shortfall;
    logic        eject_coin1, eject_coin2, eject_coin5;
    logic [7:0]  tube1_count, tube2_count, tube5_count;
    logic [15:0] paid_total;

    change_dispenser #(
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP),
        .TUBE_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amount     (amount),
        .refill     (refill),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .shortfall  (shortfall),
        .eject_coin1(eject_coin1),
        .eject_coin2(eject_coin2),
        .eject_coin5(eject_coin5),
        .tube1_count(tube1_count),
        .tube2_count(tube2_count),
        .tube5_count(tube5_count),
        .paid_total (paid_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int busy_cycles;
        int fault;
        int shortfall;
        int t1;
        int t2;
        int t5;
        int paid;
    } done_t;

    int    exp_coins[$];
    done_t exp_done[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    exp_paid = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_coin(input int c, input int n);
        for (int i = 0; i < n; i++) exp_coins.push_back(c);
    endtask

    task automatic push_done(input int bc, input int f, input int sf,
                             input int t1, input int t2, input int t5);
        done_t d;
        d.busy_cycles = bc;
        d.fault       = f;
        d.shortfall   = sf;
        d.t1          = t1;
        d.t2          = t2;
        d.t5          = t5;
        d.paid        = AUDIT ? exp_paid : 0;
        exp_done.push_back(d);
    endtask

    task automatic issue_start(input int a);
        @(posedge clk); #1;
        start  = 1'b1;
        amount = 8'(a);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic pulse_refill();
        @(posedge clk); #1;
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 400 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    int         ncnt = 0, start_neg = 0, busy_cnt = 0, plen = 0, gap_cnt = 0;
    int         first_pend = 0, in_gap = 0, multi = 0;
    logic       busy_q = 1'b0;
    logic [2:0] cur = 3'b000;
    logic [2:0] ej;

    function automatic int coin_of(input logic [2:0] v);
        case (v)
            3'b100:  return 5;
            3'b010:  return 2;
            3'b001:  return 1;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            cur        = 3'b000;
            in_gap     = 0;
            first_pend = 0;
            busy_q     = 1'b0;
            busy_cnt   = 0;
        end else begin
            ncnt++;
            ej = {eject_coin5, eject_coin2, eject_coin1};
            if (busy && !busy_q) begin
                start_neg  = ncnt;
                first_pend = 1;
                busy_cnt   = 0;
                in_gap     = 0;
            end
            if (busy) busy_cnt++;

            if (ej != 3'b000) begin
                if (cur == 3'b000) begin
                    if (first_pend != 0)
                        check("first_eject_latency", ncnt - start_neg, 2);
                    else if (in_gap != 0)
                        // GAP state plus the SELECT cycle before the next eject
                        check("idle_between_ejects", gap_cnt, GAP + 1);
                    first_pend = 0;
                    in_gap     = 0;
                    cur        = ej;
                    plen       = 1;
                    multi      = ($countones(ej) != 1) ? 1 : 0;
                end else begin
                    if (ej != cur) multi = 1;
                    plen++;
                end
            end else if (cur != 3'b000) begin
                if (exp_coins.size() == 0) begin
                    check("unexpected_coin", coin_of(cur), 0);
                end else begin
                    check("coin_value", coin_of(cur), exp_coins.pop_front());
                    check("pulse_len", plen, PULSE);
                    check("eject_onehot_stable", multi, 0);
                end
                cur     = 3'b000;
                in_gap  = 1;
                gap_cnt = 1;
            end else if (in_gap != 0) begin
                gap_cnt++;
            end

            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("busy_cycles", busy_cnt, d.busy_cycles);
                    check("fault", int'(fault), d.fault);
                    check("shortfall", int'(shortfall), d.shortfall);
                    check("tube1", int'(tube1_count), d.t1);
                    check("tube2", int'(tube2_count), d.t2);
                    check("tube5", int'(tube5_count), d.t5);
                    check("paid_total", int'(paid_total), d.paid);
                end
                in_gap     = 0;
                first_pend = 0;
            end
            busy_q = busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        rst    = 1'b0;
        start  = 1'b0;
        refill = 1'b0;
        amount = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_ejects", int'({eject_coin5, eject_coin2, eject_coin1}), 0);
        check("rst_tube1", int'(tube1_count), DEPTH);
        check("rst_tube5", int'(tube5_count), DEPTH);
        check("rst_paid", int'(paid_total), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_shortfall", int'(shortfall), 0);

        // 1: amount 8 -> 5,2,1
        push_coin(5, 1); push_coin(2, 1); push_coin(1, 1);
        exp_paid += 8;
        push_done(17, 0, 0, 2, 2, 2);
        issue_start(8);
        wait_done("t1");

        // 2: amount 0 -> done after 2 cycles, no ejects
        push_done(2, 0, 0, 2, 2, 2);
        issue_start(0);
        wait_done("t2");

        // 3: refill, 15 -> 5,5,5 ; then 7 -> 2,2,2,1
        pulse_refill();
        check("refill_tube2", int'(tube2_count), DEPTH);
        push_coin(5, 3);
        exp_paid += 15;
        push_done(17, 0, 0, 3, 3, 0);
        issue_start(15);
        wait_done("t3a");
        push_coin(2, 3); push_coin(1, 1);
        exp_paid += 7;
        push_done(22, 0, 0, 2, 0, 0);
        issue_start(7);
        wait_done("t3b");

        // 4: fresh audit total, refill, 30 -> 24 paid, shortfall 6
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_paid = 0;
        pulse_refill();
        push_coin(5, 3); push_coin(2, 3); push_coin(1, 3);
        exp_paid += 24;
        push_done(47, 1, 6, 0, 0, 0);
        issue_start(30);
        wait_done("t4");
        repeat (3) @(posedge clk);
        #1;
        check("fault_held", int'(fault), 1);
        check("shortfall_held", int'(shortfall), 6);

        // 5: start and refill while busy are ignored; fault clears on start
        pulse_refill();
        push_coin(5, 1); push_coin(2, 1); push_coin(1, 1);
        exp_paid += 8;
        push_done(17, 0, 0, 2, 2, 2);
        issue_start(8);
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        amount = 8'd5;
        refill = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        refill = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        wait_done("t5");

        // 6: asynchronous reset while eject_coin5 is high
        issue_start(8);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (eject_coin5) seen = 1;
        end
        check("t6_eject5_seen", seen, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_ejects", int'({eject_coin5, eject_coin2, eject_coin1}), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_tube5", int'(tube5_count), DEPTH);
        @(negedge clk); #1;
        rst = 1'b1;
        exp_paid = 0;
        @(posedge clk); #1;
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_tube1", int'(tube1_count), DEPTH);
        check("post_rst_tube2", int'(tube2_count), DEPTH);
        push_coin(2, 1);
        exp_paid += 2;
        push_done(7, 0, 0, 3, 2, 3);
        issue_start(2);
        wait_done("t6");

        repeat (3) @(posedge clk);
        check("coins_left", exp_coins.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
